key_entry_buffer: RTL

Parametrised keypad digit-entry buffer for the alarm/time-set path of the digital watch. It shifts validated decimal key digits into an N-digit buffer, newest digit in the least-significant position, and supports backspace and clear. A complete entry is handed to the time/alarm registers through a valid/ready commit handshake, and the buffer stays frozen until the consumer accepts it.

---
 rtl/key_entry_pkg.sv | 15 +
 rtl/digit_shift_reg.sv | 41 ++++
 rtl/key_entry_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/key_entry_pkg.sv
// Shared types and helpers for the keypad digit-entry buffer.
package key_entry_pkg;

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned MAX_DIGIT = 9;

    function automatic logic is_digit(input logic [31:0] k);
        return k <= MAX_DIGIT;
    endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Digit slot array: shift-in toward MS, zero-fill shift toward LS, clear.
module digit_shift_reg #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr_i,
    input  logic                          shl_i,
    input  logic                          shr_i,
    input  logic [DIGIT_W-1:0]            din_i,
    output logic [NUM_DIGITS*DIGIT_W-1:0] slots_o
);

    localparam int NW = NUM_DIGITS * DIGIT_W;

    logic [NW-1:0] slots_q;
    logic [NW-1:0] slots_d;

    always_comb begin
        slots_d = slots_q;
        if (clr_i) begin
            slots_d = '0;
        end else if (shr_i) begin
            slots_d = slots_q >> DIGIT_W;
        end else if (shl_i) begin
            slots_d = {slots_q[NW-DIGIT_W-1:0], din_i};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign slots_o = slots_q;

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad digit-entry buffer with backspace/clear and a valid/ready commit.
module key_entry_buffer
    import key_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 key,
    input  logic                               key_valid,
    input  logic                               backspace,
    input  logic                               clear,
    input  logic                               commit,
    input  logic                               out_ready,
    output logic [NUM_DIGITS*DIGIT_W-1:0]      digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    count,
    output logic                               full,
    output logic [NUM_DIGITS*DIGIT_W-1:0]      out_digits,
    output logic                               out_valid,
    output logic                               reject
);

    localparam int NW = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [NW-1:0] snap_q, snap_d;
    logic          valid_q, valid_d;
    logic          rej_q, rej_d;
    logic          sr_clr, sr_shl, sr_shr;

    digit_shift_reg #(
        .NUM_DIGITS(NUM_DIGITS),
        .DIGIT_W   (DIGIT_W)
    ) u_slots (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (sr_clr),
        .shl_i  (sr_shl),
        .shr_i  (sr_shr),
        .din_i  (key),
        .slots_o(digits)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        rej_d   = 1'b0;
        sr_clr  = 1'b0;
        sr_shl  = 1'b0;
        sr_shr  = 1'b0;
        unique case (state_q)
            ENTRY: begin
                if (clear) begin
                    sr_clr  = 1'b1;
                    count_d = '0;
                end else if (backspace) begin
                    if (count_q != '0) begin
                        sr_shr  = 1'b1;
                        count_d = count_q - CW'(1);
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (commit) begin
                    if (full_q) begin
                        snap_d  = digits;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (key_valid) begin
                    if (is_digit(32'(key))) begin
                        sr_shl = 1'b1;
                        // Saturate so entry keeps rolling once full.
                        if (count_q != FULL_CNT) begin
                            count_d = count_q + CW'(1);
                        end
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Hand-off and abort leave the same end state.
                if (clear || out_ready) begin
                    sr_clr  = 1'b1;
                    count_d = '0;
                    valid_d = 1'b0;
                    state_d = ENTRY;
                end
                if (!clear && (backspace || commit || key_valid)) begin
                    rej_d = 1'b1;
                end
            end
        endcase
        full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTRY;
            count_q <= '0;
            full_q  <= 1'b0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            rej_q   <= rej_d;
        end
    end

    assign count      = count_q;
    assign full       = full_q;
    assign out_digits = snap_q;
    assign out_valid  = valid_q;
    assign reject     = rej_q;

endmodule
